// File: rtl/zap_ram_multiport_if.sv
// zap_ram_multiport_if: bus bundle for zap_ram_multiport.
//   i_clken    global clock enable (freezes all state when low)
//   i_wr_en    write request; i_wr_be byte enables; i_wr_addr / i_wr_data
//   i_rd_en    per-port read request; i_rd_addr packed read addresses (AW per port)
//   o_rd_data  packed read data (WIDTH per port); o_rd_valid per-port data valid
//   o_par_err  per-port parity error (only meaningful with parity storage built in)
// Modports: master drives requests and samples results, slave is the RAM side.
interface zap_ram_multiport_if #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 32,
    parameter int unsigned NRD   = 2
);
    localparam int unsigned NB = WIDTH / 8;
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic                 i_clken;
    logic                 i_wr_en;
    logic [NB-1:0]        i_wr_be;
    logic [AW-1:0]        i_wr_addr;
    logic [WIDTH-1:0]     i_wr_data;
    logic [NRD-1:0]       i_rd_en;
    logic [NRD*AW-1:0]    i_rd_addr;
    logic [NRD*WIDTH-1:0] o_rd_data;
    logic [NRD-1:0]       o_rd_valid;
    logic [NRD-1:0]       o_par_err;

    modport master (
        output i_clken, i_wr_en, i_wr_be, i_wr_addr, i_wr_data, i_rd_en, i_rd_addr,
        input  o_rd_data, o_rd_valid, o_par_err
    );

    modport slave (
        input  i_clken, i_wr_en, i_wr_be, i_wr_addr, i_wr_data, i_rd_en, i_rd_addr,
        output o_rd_data, o_rd_valid, o_par_err
    );
endinterface

// File: rtl/zap_ram_multiport.sv
// zap_ram_multiport: RAM with NRD independent read ports, LAT-edge read latency,
// per-byte write enables and byte-granular write-to-read forwarding across every
// read pipeline stage. A read accepted at edge t returns the word after all writes
// accepted at edges t .. t+LAT-1 (newest write wins per byte).
// Ports:
//   i_clk      clock
//   i_reset_n  asynchronous active-low reset (pipeline only; the array is not reset)
//   bus        zap_ram_multiport_if.slave (clock enable, write port, read ports, results)
// Optional feature: define ZAP_RAM_MULTIPORT_PARITY_EN to store one even-parity bit
// per byte and flag o_par_err for array-sourced bytes; otherwise o_par_err is tied 0.
module zap_ram_multiport #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 32,
    parameter int unsigned NRD   = 2,
    parameter int unsigned LAT   = 3
) (
    input  logic               i_clk,
    input  logic               i_reset_n,
    zap_ram_multiport_if.slave bus
);
    localparam int unsigned NB = WIDTH / 8;
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // One read in flight: its address, array snapshot taken at acceptance and the
    // bytes overwritten by later writes (mask/fwd).
    typedef struct packed {
        logic [AW-1:0]    addr;
        logic             valid;
        logic [NB-1:0]    mask;
        logic [WIDTH-1:0] fwd;
        logic [WIDTH-1:0] arr;
        logic [NB-1:0]    par;
    } stage_t;

    function automatic stage_t merge(input stage_t cur, input logic hit,
                                     input logic [NB-1:0] be, input logic [WIDTH-1:0] wd);
        stage_t r;
        r = cur;
        for (int unsigned k = 0; k < NB; k++) begin
            if (hit && be[k]) begin
                r.mask[k]        = 1'b1;
                r.fwd[8*k +: 8]  = wd[8*k +: 8];
            end
        end
        return r;
    endfunction

`ifdef ZAP_RAM_MULTIPORT_PARITY_EN
    function automatic logic [NB-1:0] byte_par(input logic [WIDTH-1:0] w);
        logic [NB-1:0] r;
        r = '0;
        for (int unsigned k = 0; k < NB; k++) begin
            r[k] = ^w[8*k +: 8];
        end
        return r;
    endfunction
`endif

    logic [WIDTH-1:0] mem [DEPTH];
`ifdef ZAP_RAM_MULTIPORT_PARITY_EN
    logic [NB-1:0]    mem_par [DEPTH];
`endif

    stage_t st [NRD][LAT];
    stage_t nx [NRD][LAT];

    // Writes to addresses beyond DEPTH are dropped and never forwarded.
    logic wr_ok;
    if ((1 << AW) == DEPTH) begin : g_pow2
        assign wr_ok = bus.i_wr_en;
    end else begin : g_npow2
        assign wr_ok = bus.i_wr_en && (32'(bus.i_wr_addr) < DEPTH);
    end

    always_ff @(posedge i_clk) begin
        if (bus.i_clken && wr_ok) begin
            for (int unsigned k = 0; k < NB; k++) begin
                if (bus.i_wr_be[k]) begin
                    mem[bus.i_wr_addr][8*k +: 8] <= bus.i_wr_data[8*k +: 8];
`ifdef ZAP_RAM_MULTIPORT_PARITY_EN
                    mem_par[bus.i_wr_addr][k] <= ^bus.i_wr_data[8*k +: 8];
`endif
                end
            end
        end
    end

    for (genvar p = 0; p < NRD; p++) begin : g_port
        stage_t           head;
        stage_t           fin;
        logic [WIDTH-1:0] word;
        logic             perr;

        // The array is sampled before this edge's write; that write reaches the read
        // through the stage-0 merge instead, giving write-first behaviour.
        always_comb begin
            head       = '0;
            head.addr  = bus.i_rd_addr[p*AW +: AW];
            head.valid = bus.i_rd_en[p];
            head.arr   = mem[head.addr];
`ifdef ZAP_RAM_MULTIPORT_PARITY_EN
            head.par   = mem_par[head.addr];
`endif
        end

        for (genvar s = 0; s < LAT; s++) begin : g_stage
            if (s == 0) begin : g_first
                assign nx[p][s] = merge(head, wr_ok && (head.addr == bus.i_wr_addr),
                                        bus.i_wr_be, bus.i_wr_data);
            end else begin : g_next
                assign nx[p][s] = merge(st[p][s-1], wr_ok && (st[p][s-1].addr == bus.i_wr_addr),
                                        bus.i_wr_be, bus.i_wr_data);
            end
        end

        assign fin = st[p][LAT-1];

        always_comb begin
            word = fin.arr;
            for (int unsigned k = 0; k < NB; k++) begin
                if (fin.mask[k]) begin
                    word[8*k +: 8] = fin.fwd[8*k +: 8];
                end
            end
        end

`ifdef ZAP_RAM_MULTIPORT_PARITY_EN
        // Only bytes that came from the array are checked; forwarded bytes are fresh.
        assign perr = fin.valid && (|(~fin.mask & (fin.par ^ byte_par(fin.arr))));
`else
        assign perr = 1'b0;
`endif

        assign bus.o_rd_data[p*WIDTH +: WIDTH] = word;
        assign bus.o_rd_valid[p]               = fin.valid;
        assign bus.o_par_err[p]                = perr;
    end

    // The last stage only takes new contents with a valid read, so the output word
    // holds the last returned data while o_rd_valid is low.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            for (int unsigned p = 0; p < NRD; p++) begin
                for (int unsigned s = 0; s < LAT; s++) begin
                    st[p][s] <= '0;
                end
            end
        end else if (bus.i_clken) begin
            for (int unsigned p = 0; p < NRD; p++) begin
                for (int unsigned s = 0; s < LAT; s++) begin
                    if ((s + 1 == LAT) && !nx[p][s].valid) begin
                        st[p][s].valid <= 1'b0;
                    end else begin
                        st[p][s] <= nx[p][s];
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_zap_ram_multiport.sv
// tb_zap_ram_multiport: directed scoreboard bench for zap_ram_multiport
// (WIDTH=32, DEPTH=32, NRD=2, LAT=3). Reads push hand-computed expectations with
// their due enabled-edge count; a negedge monitor pops and compares on o_rd_valid,
// and checks hold/zero behaviour otherwise.
module tb_zap_ram_multiport;
    localparam int unsigned WIDTH = 32;
    localparam int unsigned DEPTH = 32;
    localparam int unsigned NRD   = 2;
    localparam int unsigned LAT   = 3;
    localparam int unsigned AW    = 5;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    zap_ram_multiport_if #(.WIDTH(WIDTH), .DEPTH(DEPTH), .NRD(NRD)) bif ();

    zap_ram_multiport #(.WIDTH(WIDTH), .DEPTH(DEPTH), .NRD(NRD), .LAT(LAT)) dut (
        .i_clk     (clk),
        .i_reset_n (rst_n),
        .bus       (bif)
    );

    typedef struct {
        logic [31:0] data;
        logic        par;
        int unsigned due;
    } exp_t;

    exp_t        q0[$];
    exp_t        q1[$];
    int unsigned tests = 0;
    int unsigned fails = 0;
    int unsigned cnt   = 0;
    logic [31:0] last      [NRD];
    int unsigned popped_at [NRD];
    logic [31:0] pend_d    [NRD];
    logic        pend_p    [NRD];

    always @(posedge clk) begin
        if (bif.i_clken) cnt++;
    end

    task automatic chk(input string name, input int unsigned port,
                       input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s port%0d: got 0x%08h, expected 0x%08h", name, port, act, exp);
        end
    endtask

    task automatic wr(input logic [3:0] be, input logic [4:0] a, input logic [31:0] d);
        bif.i_wr_en   = 1'b1;
        bif.i_wr_be   = be;
        bif.i_wr_addr = a;
        bif.i_wr_data = d;
    endtask

    task automatic rd(input int p, input logic [4:0] a, input logic [31:0] e, input logic pe);
        bif.i_rd_en[p]             = 1'b1;
        bif.i_rd_addr[p*AW +: AW]  = a;
        pend_d[p]                  = e;
        pend_p[p]                  = pe;
    endtask

    task automatic tick(input logic ce);
        exp_t e;
        bif.i_clken = ce;
        if (ce) begin
            for (int p = 0; p < NRD; p++) begin
                if (bif.i_rd_en[p]) begin
                    e.data = pend_d[p];
                    e.par  = pend_p[p];
                    e.due  = cnt + LAT;
                    if (p == 0) q0.push_back(e);
                    else        q1.push_back(e);
                end
            end
        end
        @(posedge clk);
        #1;
        bif.i_wr_en = 1'b0;
        bif.i_rd_en = '0;
        bif.i_clken = 1'b1;
    endtask

    always @(negedge clk) begin : monitor
        logic [31:0] act;
        exp_t        e;
        int unsigned qs;
        for (int p = 0; p < NRD; p++) begin
            act = bif.o_rd_data[p*WIDTH +: WIDTH];
            qs  = (p == 0) ? q0.size() : q1.size();
            if (!rst_n) begin
                chk("reset_data", p, act, 32'h0);
                chk("reset_valid", p, 32'(bif.o_rd_valid[p]), 32'h0);
            end else if (bif.o_rd_valid[p] && cnt != popped_at[p]) begin
                popped_at[p] = cnt;
                if (qs == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_valid port%0d: got valid with data 0x%08h, expected no read", p, act);
                end else begin
                    if (p == 0) e = q0.pop_front();
                    else        e = q1.pop_front();
                    chk("rd_data", p, act, e.data);
                    chk("par_err", p, 32'(bif.o_par_err[p]), 32'(e.par));
                    chk("latency", p, cnt, e.due);
                    last[p] = e.data;
                end
            end else begin
                chk("hold_data", p, act, last[p]);
                if (!bif.o_rd_valid[p]) chk("idle_par_err", p, 32'(bif.o_par_err[p]), 32'h0);
            end
        end
    end

    initial begin
        for (int p = 0; p < NRD; p++) begin
            last[p]      = '0;
            popped_at[p] = 32'hFFFF_FFFF;
            pend_d[p]    = '0;
            pend_p[p]    = 1'b0;
        end
        bif.i_clken   = 1'b1;
        bif.i_wr_en   = 1'b0;
        bif.i_wr_be   = '0;
        bif.i_wr_addr = '0;
        bif.i_wr_data = '0;
        bif.i_rd_en   = '0;
        bif.i_rd_addr = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // basic write then read two cycles later
        wr(4'hF, 5'd5, 32'hDEADBEEF); tick(1);
        tick(1);
        rd(0, 5'd5, 32'hDEADBEEF, 1'b0); tick(1);

        // same-edge forwarding
        wr(4'hF, 5'd7, 32'h11111111); tick(1);
        wr(4'h3, 5'd7, 32'hAABBCCDD); rd(0, 5'd7, 32'h1111CCDD, 1'b0); tick(1);

        // in-flight merge; port1 joins one edge later and also sees the t+3 write
        wr(4'hF, 5'd2, 32'h00000000); tick(1);
        rd(0, 5'd2, 32'hBB0000AA, 1'b0); tick(1);
        wr(4'h1, 5'd2, 32'h000000AA); rd(1, 5'd2, 32'hBB00CCAA, 1'b0); tick(1);
        wr(4'h8, 5'd2, 32'hBB000000); tick(1);
        wr(4'h2, 5'd2, 32'h0000CC00); tick(1);

        // dual port with clock-enable stalls; stalled requests must be ignored
        wr(4'hF, 5'd1, 32'h00000001); tick(1);
        wr(4'hF, 5'd3, 32'h00000003); tick(1);
        rd(0, 5'd1, 32'h00000001, 1'b0); rd(1, 5'd3, 32'h00000003, 1'b0); tick(1);
        tick(1);
        repeat (4) begin
            wr(4'hF, 5'd1, 32'hFFFFFFFF); rd(0, 5'd3, 32'h0, 1'b0); tick(0);
        end
        tick(1);
        repeat (2) tick(0);
        tick(1);

        // back-to-back on both ports, including same address on both
        rd(0, 5'd5, 32'hDEADBEEF, 1'b0); rd(1, 5'd1, 32'h00000001, 1'b0); tick(1);
        rd(0, 5'd7, 32'h1111CCDD, 1'b0); rd(1, 5'd3, 32'h00000003, 1'b0); tick(1);
        rd(0, 5'd2, 32'hBB00CCAA, 1'b0); rd(1, 5'd5, 32'hDEADBEEF, 1'b0); tick(1);
        rd(0, 5'd5, 32'hDEADBEEF, 1'b0); rd(1, 5'd5, 32'hDEADBEEF, 1'b0); tick(1);
        repeat (LAT + 1) tick(1);

        // reset with reads in flight
        rd(0, 5'd5, 32'hDEADBEEF, 1'b0); tick(1);
        rd(1, 5'd3, 32'h00000003, 1'b0); tick(1);
        @(negedge clk);
        #2;
        q0.delete();
        q1.delete();
        for (int p = 0; p < NRD; p++) begin
            last[p]      = '0;
            popped_at[p] = 32'hFFFF_FFFF;
        end
        rst_n = 1'b0;
        #1;
        chk("reset_mid_data", 0, bif.o_rd_data[31:0], 32'h0);
        chk("reset_mid_data", 1, bif.o_rd_data[63:32], 32'h0);
        chk("reset_mid_valid", 0, 32'(bif.o_rd_valid), 32'h0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        repeat (LAT + 2) tick(1);
        rd(0, 5'd5, 32'hDEADBEEF, 1'b0); tick(1);

        // parity: corrupted array byte vs. fully forwarded word
        wr(4'hF, 5'd4, 32'h12345678); tick(1);
        tick(1);
`ifdef ZAP_RAM_MULTIPORT_PARITY_EN
        dut.mem[4][0] = ~dut.mem[4][0];
        rd(0, 5'd4, 32'h12345679, 1'b1); tick(1);
`else
        rd(0, 5'd4, 32'h12345678, 1'b0); tick(1);
`endif
        tick(1);
        rd(0, 5'd4, 32'hCAFEF00D, 1'b0); tick(1);
        wr(4'hF, 5'd4, 32'hCAFEF00D); tick(1);
        repeat (LAT + 2) tick(1);

        chk("queue_drain", 0, q0.size(), 32'h0);
        chk("queue_drain", 1, q1.size(), 32'h0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
